// File: rtl/uart_tx_port.sv
// Memory-mapped 8N1 UART transmitter that snoops the CPU data bus.
// Bytes written to TX_ADDR queue in a FIFO; STAT_ADDR reads return a registered status word.
module uart_tx_port #(
  parameter int unsigned CLK_DIV    = 434,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [15:0] TX_ADDR    = 16'h3FFE,
  parameter logic [15:0] STAT_ADDR  = 16'h3FFD
) (
  input  logic        clk,
  input  logic        nRst,
  input  logic [15:0] dataAddress,
  input  logic [31:0] writeDataIn,
  input  logic        dataWrEn,
  output logic [31:0] statusOut,
  output logic        statusSel,
  output logic        txd
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned BAUD_W = $clog2(CLK_DIV);

  localparam logic [BAUD_W-1:0] BAUD_RELOAD = BAUD_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0]  DEPTH_C     = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_e;

  // Count field is 5 bits wide so it holds up to 16 entries.
  function automatic logic [31:0] pack_status(
    input logic [CNT_W-1:0] cnt,
    input logic             empty,
    input logic             full,
    input logic             busy,
    input logic             ovf
  );
    logic [31:0] w;
    w       = 32'h0000_0000;
    w[0]    = empty;
    w[1]    = full;
    w[2]    = busy;
    w[3]    = ovf;
    w[12:8] = 5'(cnt);
    return w;
  endfunction

  logic [7:0]        mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ovf_q, ovf_d;

  state_e            state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [7:0]        shift_q, shift_d;
  logic [2:0]        idx_q, idx_d;
  logic              txd_q, txd_d;

  logic [31:0]       status_q, status_d;
  logic              sel_q, sel_d;

  logic              push_req_s, push_s, pop_s;
  logic              empty_s, full_s, clr_s, stat_rd_s;
  logic              unused_s;

  assign unused_s = ^writeDataIn[31:8];

  assign empty_s    = (count_q == '0);
  assign full_s     = (count_q == DEPTH_C);
  assign push_req_s = dataWrEn && (dataAddress == TX_ADDR);
  assign push_s     = push_req_s && !full_s;
  assign pop_s      = (state_q == ST_IDLE) && !empty_s;
  assign clr_s      = dataWrEn && (dataAddress == STAT_ADDR) && writeDataIn[0];
  assign stat_rd_s  = (dataAddress == STAT_ADDR) && !dataWrEn;

  // FIFO pointer, count and sticky overflow next-state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;

    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    // A dropped push beats a same-edge clear.
    if (push_req_s && full_s) begin
      ovf_d = 1'b1;
    end else if (clr_s) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Serialiser FSM next-state: start bit, 8 data bits LSB first, stop bit
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    txd_d   = txd_q;

    case (state_q)
      ST_IDLE: begin
        txd_d = 1'b1;
        if (!empty_s) begin
          shift_d = mem_q[rd_ptr_q];
          txd_d   = 1'b0;
          baud_d  = BAUD_RELOAD;
          idx_d   = 3'd0;
          state_d = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (baud_q == '0) begin
          txd_d   = shift_q[0];
          baud_d  = BAUD_RELOAD;
          state_d = ST_DATA;
        end else begin
          baud_d = baud_q - BAUD_W'(1);
        end
      end
      ST_DATA: begin
        if (baud_q == '0) begin
          baud_d = BAUD_RELOAD;
          if (idx_q < 3'd7) begin
            shift_d = {1'b0, shift_q[7:1]};
            idx_d   = idx_q + 3'd1;
            txd_d   = shift_q[1];
          end else begin
            txd_d   = 1'b1;
            state_d = ST_STOP;
          end
        end else begin
          baud_d = baud_q - BAUD_W'(1);
        end
      end
      ST_STOP: begin
        if (baud_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          baud_d = baud_q - BAUD_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        txd_d   = 1'b1;
      end
    endcase
  end

  // Status capture: only a read of STAT_ADDR refreshes the word
  always_comb begin
    sel_d    = stat_rd_s;
    status_d = status_q;
    if (stat_rd_s) begin
      status_d = pack_status(count_q, empty_s, full_s, (state_q != ST_IDLE), ovf_q);
    end else begin
      status_d = status_q;
    end
  end

  // FIFO storage
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        mem_q[i] <= 8'h00;
      end
    end else if (push_s) begin
      mem_q[wr_ptr_q] <= writeDataIn[7:0];
    end
  end

  // State registers; reset drives txd high immediately
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      state_q  <= ST_IDLE;
      baud_q   <= '0;
      shift_q  <= 8'h00;
      idx_q    <= 3'd0;
      txd_q    <= 1'b1;
      status_q <= 32'h0000_0000;
      sel_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      state_q  <= state_d;
      baud_q   <= baud_d;
      shift_q  <= shift_d;
      idx_q    <= idx_d;
      txd_q    <= txd_d;
      status_q <= status_d;
      sel_q    <= sel_d;
    end
  end

  assign txd       = txd_q;
  assign statusOut = status_q;
  assign statusSel = sel_q;

endmodule

// File: tb/tb_uart_tx_port.sv
// Scoreboard bench for uart_tx_port: expected status words and frames are queued by the
// stimulus; a status monitor and a UART receiver pop and compare as the DUT produces them.
module tb_uart_tx_port;

  localparam int          DIV   = 4;
  localparam logic [15:0] TXA   = 16'h3FFE;
  localparam logic [15:0] STA   = 16'h3FFD;

  typedef struct {
    logic [7:0] b;
    int         start;
  } frame_t;

  logic        clk = 1'b0;
  logic        nRst;
  logic [15:0] addr;
  logic [31:0] wdata;
  logic        wr;
  logic [31:0] statusOut;
  logic        statusSel;
  logic        txd;

  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  bit          rx_en = 1'b1;
  logic [31:0] sq[$];
  frame_t      fq[$];

  uart_tx_port #(.CLK_DIV(DIV), .FIFO_DEPTH(8), .TX_ADDR(TXA), .STAT_ADDR(STA)) dut (
    .clk(clk), .nRst(nRst), .dataAddress(addr), .writeDataIn(wdata), .dataWrEn(wr),
    .statusOut(statusOut), .statusSel(statusSel), .txd(txd)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic at(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic drive(input logic [15:0] a, input logic [31:0] d, input logic w);
    addr  = a;
    wdata = d;
    wr    = w;
  endtask

  task automatic push(input int t, input logic [7:0] b);
    at(t);
    drive(TXA, {24'h0, b}, 1'b1);
    at(t + 1);
    drive(16'h0, 32'h0, 1'b0);
  endtask

  task automatic rd(input int t, input logic [31:0] e);
    at(t);
    drive(STA, 32'h0, 1'b0);
    sq.push_back(e);
    at(t + 1);
    drive(16'h0, 32'h0, 1'b0);
  endtask

  task automatic expect_frame(input logic [7:0] b, input int s);
    fq.push_back('{b: b, start: s});
  endtask

  // Status monitor: every statusSel pulse must match the next queued word
  always @(negedge clk) begin
    if (nRst === 1'b1 && statusSel === 1'b1) begin
      if (sq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL status_unexpected: got %h expected no read", statusOut);
      end else begin
        check("status", statusOut, sq.pop_front());
      end
    end
  end

  // UART receiver: samples every cycle so bit lengths and start cycle are exact
  initial begin : rx
    int         s;
    logic [9:0] fb;
    logic       stable;
    frame_t     e;
    forever begin
      @(negedge clk);
      if (rx_en && nRst === 1'b1 && txd === 1'b0) begin
        s      = cyc;
        stable = 1'b1;
        fb     = 10'h0;
        for (int b = 0; b < 10; b++) begin
          for (int j = 0; j < DIV; j++) begin
            if (b != 0 || j != 0) @(negedge clk);
            if (j == 0) fb[b] = txd;
            else if (txd !== fb[b]) stable = 1'b0;
          end
        end
        if (fq.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL frame_unexpected: got byte %h expected no frame (start %0d)", fb[8:1], s);
        end else begin
          e = fq.pop_front();
          check("frame_data", 32'(fb[8:1]), 32'(e.b));
          check("frame_shape", {29'h0, stable, fb[0], fb[9]}, 32'h5);
          if (e.start >= 0) check("frame_start", 32'(s), 32'(e.start));
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int c;
    nRst = 1'b1;
    drive(16'h0, 32'h0, 1'b0);
    #1 nRst = 1'b0;
    #1;
    check("reset_txd", 32'(txd), 32'h1);
    check("reset_sel", 32'(statusSel), 32'h0);
    check("reset_status", statusOut, 32'h0);
    repeat (3) @(negedge clk);
    nRst = 1'b1;
    c = cyc + 2;
    rd(c, 32'h0000_0001);

    // Reset in the middle of a frame
    rx_en = 1'b0;
    c = cyc + 2;
    push(c, 8'h00);
    at(c + 12);
    check("pre_reset_txd", 32'(txd), 32'h0);
    @(posedge clk);
    #2 nRst = 1'b0;
    #1 check("async_reset_txd", 32'(txd), 32'h1);
    @(negedge clk);
    nRst = 1'b1;
    rx_en = 1'b1;
    c = cyc + 2;
    rd(c, 32'h0000_0001);

    // Single byte A5
    c = cyc + 2;
    expect_frame(8'hA5, c + 2);
    push(c, 8'hA5);
    rd(c + 2, 32'h0000_0005);
    rd(c + 20, 32'h0000_0005);
    rd(c + 41, 32'h0000_0005);
    rd(c + 42, 32'h0000_0001);
    at(c + 50);

    // Back-to-back frames with a single idle cycle between them
    c = cyc + 2;
    expect_frame(8'h01, c + 2);
    expect_frame(8'h02, c + 43);
    expect_frame(8'h03, c + 84);
    at(c);     drive(TXA, 32'h01, 1'b1);
    at(c + 1); drive(TXA, 32'h02, 1'b1);
    at(c + 2); drive(TXA, 32'h03, 1'b1);
    rd(c + 3, 32'h0000_0204);
    rd(c + 42, 32'h0000_0200);
    rd(c + 43, 32'h0000_0104);
    rd(c + 84, 32'h0000_0005);
    at(c + 130);

    // Overflow: ten pushes, then a push on the edge an IDLE pop frees a slot
    c = cyc + 2;
    for (int k = 0; k < 9; k++) expect_frame(8'h10 + 8'(k), c + 2 + 41 * k);
    for (int k = 0; k < 10; k++) begin
      at(c + k);
      drive(TXA, 32'h10 + 32'(k), 1'b1);
    end
    rd(c + 10, 32'h0000_080E);
    push(c + 42, 8'hEE);
    rd(c + 43, 32'h0000_070C);
    at(c + 380);

    // Flag clear: bit0=0 leaves overflow set, bit0=1 clears it
    c = cyc + 2;
    expect_frame(8'h3C, c + 5);
    at(c); drive(STA, 32'h2, 1'b1);
    rd(c + 1, 32'h0000_0009);
    at(c + 2); drive(STA, 32'h1, 1'b1);
    at(c + 3); drive(TXA, 32'h3C, 1'b1);
    rd(c + 4, 32'h0000_0100);
    rd(c + 5, 32'h0000_0005);
    at(c + 60);

    check("frames_pending", 32'(fq.size()), 32'h0);
    check("status_pending", 32'(sq.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
